// File: rtl/phase_incr_rom_arbiter.sv
// phase_incr_rom_arbiter
//   Shares a dual-read-port synchronous phase-increment ROM between N_REQ
//   DDS channel requesters. Each cycle it grants up to two distinct
//   requesters in round-robin order, one per ROM port. It tracks each lookup
//   through the ROM latency and returns the result to its owner with a
//   one-cycle valid pulse.
// Ports:
//   clk, rst               clock (rising edge), async active-high reset
//   req / req_idx          per-requester request and packed table index
//   gnt                    combinational accept, at most two bits high
//   rsp_valid / rsp_dphi   registered per-requester result pulse and data
//   rom_addr_a/b           combinational ROM addresses
//   rom_dout_a/b           ROM data, ROM_LAT cycles after the address

// Per-requester response register. A given requester completes on at most
// one port per cycle, so the priority between hit_a and hit_b is never
// exercised.
module phase_incr_rsp_lane #(
    parameter int PHASE_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hit_a,
    input  logic               hit_b,
    input  logic [PHASE_W-1:0] dout_a,
    input  logic [PHASE_W-1:0] dout_b,
    output logic               rsp_valid,
    output logic [PHASE_W-1:0] rsp_dphi
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_dphi  <= '0;
        end else begin
            rsp_valid <= hit_a | hit_b;
            if (hit_a)      rsp_dphi <= dout_a;
            else if (hit_b) rsp_dphi <= dout_b;
        end
    end
endmodule

module phase_incr_rom_arbiter #(
    parameter int N_REQ   = 4,
    parameter int IDX_W   = 10,
    parameter int PHASE_W = 32,
    parameter int ROM_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*IDX_W-1:0]   req_idx,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [N_REQ*PHASE_W-1:0] rsp_dphi,
    output logic [IDX_W-1:0]         rom_addr_a,
    output logic [IDX_W-1:0]         rom_addr_b,
    input  logic [PHASE_W-1:0]       rom_dout_a,
    input  logic [PHASE_W-1:0]       rom_dout_b
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0][IDX_W-1:0]   idx_v;
    logic [N_REQ-1:0][PHASE_W-1:0] dphi_v;
    logic [ID_W-1:0]               rr_ptr;
    logic [ID_W-1:0]               win_a, win_b, scan_id;
    logic                          a_vld, b_vld;

    logic [ROM_LAT-1:0]            vld_pipe_a, vld_pipe_b;
    logic [ROM_LAT-1:0][ID_W-1:0]  id_pipe_a, id_pipe_b;
    logic [N_REQ-1:0]              hit_a, hit_b;

    assign idx_v    = req_idx;
    assign rsp_dphi = dphi_v;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(N_REQ-1)) ? '0 : id + 1'b1;
    endfunction

    // Round-robin scan from rr_ptr: first requester found takes port A,
    // the next distinct one takes port B. Nothing is granted in reset.
    always_comb begin
        a_vld   = 1'b0;
        b_vld   = 1'b0;
        win_a   = '0;
        win_b   = '0;
        scan_id = '0;
        for (int k = 0; k < N_REQ; k++) begin
            scan_id = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (req[scan_id] && !rst) begin
                if (!a_vld) begin
                    a_vld = 1'b1;
                    win_a = scan_id;
                end else if (!b_vld) begin
                    b_vld = 1'b1;
                    win_b = scan_id;
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (a_vld) gnt[win_a] = 1'b1;
        if (b_vld) gnt[win_b] = 1'b1;
    end

    assign rom_addr_a = a_vld ? idx_v[win_a] : '0;
    assign rom_addr_b = b_vld ? idx_v[win_b] : '0;

    // Pointer moves past the last granted requester (B outranks A).
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rr_ptr <= '0;
        else if (b_vld) rr_ptr <= next_id(win_b);
        else if (a_vld) rr_ptr <= next_id(win_a);
    end

    // Tracking pipes mirror the ROM latency so the last stage lines up
    // with rom_dout of the same port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe_a <= '0;
            vld_pipe_b <= '0;
            id_pipe_a  <= '0;
            id_pipe_b  <= '0;
        end else begin
            vld_pipe_a[0] <= a_vld;
            vld_pipe_b[0] <= b_vld;
            id_pipe_a[0]  <= win_a;
            id_pipe_b[0]  <= win_b;
            for (int s = 1; s < ROM_LAT; s++) begin
                vld_pipe_a[s] <= vld_pipe_a[s-1];
                vld_pipe_b[s] <= vld_pipe_b[s-1];
                id_pipe_a[s]  <= id_pipe_a[s-1];
                id_pipe_b[s]  <= id_pipe_b[s-1];
            end
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign hit_a[i] = vld_pipe_a[ROM_LAT-1] && (id_pipe_a[ROM_LAT-1] == ID_W'(i));
        assign hit_b[i] = vld_pipe_b[ROM_LAT-1] && (id_pipe_b[ROM_LAT-1] == ID_W'(i));

        phase_incr_rsp_lane #(.PHASE_W(PHASE_W)) u_lane (
            .clk       (clk),
            .rst       (rst),
            .hit_a     (hit_a[i]),
            .hit_b     (hit_b[i]),
            .dout_a    (rom_dout_a),
            .dout_b    (rom_dout_b),
            .rsp_valid (rsp_valid[i]),
            .rsp_dphi  (dphi_v[i])
        );
    end
endmodule

// File: tb/tb_phase_incr_rom_arbiter.sv
// Bench for phase_incr_rom_arbiter: table of {req, idx, expected gnt/addr}
// vectors plus hand sequences for reset corners. Expected responses are
// pushed to a scoreboard (due two cycles after the grant, data = 3*idx) and
// popped when due.
module tb_phase_incr_rom_arbiter;
    localparam int N = 4;
    localparam int IW = 10;
    localparam int PW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req;
    logic [N-1:0][IW-1:0] idx_v;
    logic [N*IW-1:0]   req_idx;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rsp_valid;
    logic [N*PW-1:0]   rsp_dphi;
    logic [IW-1:0]     rom_addr_a, rom_addr_b;
    logic [PW-1:0]     rom_dout_a, rom_dout_b;

    assign req_idx = idx_v;

    always #5 clk = ~clk;

    // Synchronous ROM model, latency 1, dout = 3*addr
    always @(posedge clk) begin
        rom_dout_a <= PW'(3 * rom_addr_a);
        rom_dout_b <= PW'(3 * rom_addr_b);
    end

    phase_incr_rom_arbiter #(.N_REQ(N), .IDX_W(IW), .PHASE_W(PW), .ROM_LAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_idx    (req_idx),
        .gnt        (gnt),
        .rsp_valid  (rsp_valid),
        .rsp_dphi   (rsp_dphi),
        .rom_addr_a (rom_addr_a),
        .rom_addr_b (rom_addr_b),
        .rom_dout_a (rom_dout_a),
        .rom_dout_b (rom_dout_b)
    );

    typedef struct {
        logic [N-1:0]         req;
        logic [N-1:0][IW-1:0] idx;
        logic [N-1:0]         gnt;
        logic [IW-1:0]        a;
        logic [IW-1:0]        b;
    } vec_t;

    typedef struct {
        int          due;
        int          id;
        logic [PW-1:0] data;
    } sb_t;

    vec_t tbl[13];
    sb_t  sb[$];
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    function automatic vec_t mk(logic [N-1:0] r, int i3, int i2, int i1, int i0,
                                logic [N-1:0] g, int a, int b);
        vec_t v;
        v.req = r;
        v.idx = {IW'(i3), IW'(i2), IW'(i1), IW'(i0)};
        v.gnt = g;
        v.a   = IW'(a);
        v.b   = IW'(b);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, cyc, act, exp);
    endtask

    // Response side: everything due this cycle must be present, nothing else.
    task automatic check_rsp();
        logic [N-1:0] exp_v;
        sb_t e;
        exp_v = '0;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) chk("rsp_overdue", 64'(e.due), 64'(cyc));
            exp_v[e.id] = 1'b1;
            chk($sformatf("rsp_dphi[%0d]", e.id), 64'(rsp_dphi[e.id*PW +: PW]), 64'(e.data));
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
    endtask

    // One cycle: check combinational outputs at the negedge, queue expected
    // responses for the grants, check responses, then advance past posedge.
    task automatic run_cycle(input logic [N-1:0] eg, input logic [IW-1:0] ea,
                             input logic [IW-1:0] eb, input bit push);
        @(negedge clk);
        chk("gnt", 64'(gnt), 64'(eg));
        chk("rom_addr_a", 64'(rom_addr_a), 64'(ea));
        chk("rom_addr_b", 64'(rom_addr_b), 64'(eb));
        if (push)
            for (int i = 0; i < N; i++)
                if (eg[i]) sb.push_back('{cyc + 2, i, PW'(3 * idx_v[i])});
        check_rsp();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        // Reset state, with all requests high: nothing may be granted
        req   = '1;
        idx_v = {10'd13, 10'd12, 10'd11, 10'd10};
        #1;
        chk("reset_dphi_zero", 64'(rsp_dphi != '0), 64'd0);
        run_cycle('0, '0, '0, 1'b0);
        run_cycle('0, '0, '0, 1'b0);
        rst = 1'b0;

        tbl[0]  = mk(4'b0100,   0,   5,  0,   0, 4'b0100,   5,   0); // single req
        tbl[1]  = mk(4'b0000,   0,   0,  0,   0, 4'b0000,   0,   0); // idle, rr=3
        tbl[2]  = mk(4'b1111,  13,  12, 11,  10, 4'b1001,  13,  10); // wrap 3,0
        tbl[3]  = mk(4'b1111,  13,  12, 11,  10, 4'b0110,  11,  12);
        tbl[4]  = mk(4'b0010,   0,   0, 20,   0, 4'b0010,  20,   0); // rr -> 2
        tbl[5]  = mk(4'b1010,  22,   0, 21,   0, 4'b1010,  22,  21); // 3 on A, 1 on B
        tbl[6]  = mk(4'b0011,   0,   0,  7,   7, 4'b0011,   7,   7); // same index
        tbl[7]  = mk(4'b0001,   0,   0,  0,   1, 4'b0001,   1,   0); // back-to-back
        tbl[8]  = mk(4'b0001,   0,   0,  0,   2, 4'b0001,   2,   0);
        tbl[9]  = mk(4'b0001,   0,   0,  0,   4, 4'b0001,   4,   0);
        tbl[10] = mk(4'b0000, 500, 600, 700, 800, 4'b0000,  0,   0); // idle idx ignored
        tbl[11] = mk(4'b1000,   3,   0,  0, 999, 4'b1000,   3,   0); // rr=1 -> 3
        tbl[12] = mk(4'b0101,   0, 200,  0, 100, 4'b0101, 100, 200); // rr=0

        for (int v = 0; v < 13; v++) begin
            req   = tbl[v].req;
            idx_v = tbl[v].idx;
            run_cycle(tbl[v].gnt, tbl[v].a, tbl[v].b, 1'b1);
        end
        req = '0;
        run_cycle('0, '0, '0, 1'b0);
        run_cycle('0, '0, '0, 1'b0);

        // Reset with a lookup in flight: it must never return
        req   = 4'b0010;
        idx_v = {10'd0, 10'd0, 10'd50, 10'd0};
        run_cycle(4'b0010, 10'd50, '0, 1'b0);   // rr was 3 -> requester 1 on A
        rst = 1'b1;
        #1;
        chk("midrst_dphi_zero", 64'(rsp_dphi != '0), 64'd0);
        chk("midrst_valid_zero", 64'(rsp_valid), 64'd0);
        run_cycle('0, '0, '0, 1'b0);
        rst = 1'b0;
        run_cycle(4'b0010, 10'd50, '0, 1'b1);   // no stale pulse this cycle
        req = '0;
        for (int i = 0; i < 3; i++) run_cycle('0, '0, '0, 1'b0);

        // All requesters held from reset release: pairs {0,1},{2,3},...
        rst   = 1'b1;
        req   = '1;
        idx_v = {10'd13, 10'd12, 10'd11, 10'd10};
        run_cycle('0, '0, '0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) run_cycle(4'b0011, 10'd10, 10'd11, 1'b1);
            else            run_cycle(4'b1100, 10'd12, 10'd13, 1'b1);
        end
        req = '0;
        for (int i = 0; i < 3; i++) run_cycle('0, '0, '0, 1'b0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/phase_incr_rom_arbiter.md
Name: phase_incr_rom_arbiter

Overview:
Shares the dual-read-port phase-increment ROM between N_REQ independent DDS channel requesters. Each cycle it picks up to two distinct requesters in round-robin order and drives their table indices onto ROM ports A and B. It tracks each lookup through the ROM read latency and returns the phase increment to the owning requester with a valid pulse. It sits between the per-channel DDS phase accumulators and the synchronous ROM instance.

Parameters:
N_REQ, 4, number of requesters; must be >= 2
IDX_W, 10, ROM index width
PHASE_W, 32, phase increment width
ROM_LAT, 1, ROM read latency in cycles, from address to dout; must be >= 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req  in  N_REQ  per-requester lookup request; held until the matching gnt bit
req_idx  in  N_REQ*IDX_W  per-requester index; slice i is [i*IDX_W +: IDX_W]; stable while req[i] is high
gnt  out  N_REQ  combinational; bit i high means requester i's lookup is accepted this cycle
rsp_valid  out  N_REQ  registered one-cycle pulse; result for requester i is present
rsp_dphi  out  N_REQ*PHASE_W  registered per-requester result; slice i updates only when rsp_valid[i] pulses, otherwise holds
rom_addr_a  out  IDX_W  ROM port A address, combinational
rom_addr_b  out  IDX_W  ROM port B address, combinational
rom_dout_a  in  PHASE_W  ROM port A data, valid ROM_LAT cycles after the address
rom_dout_b  in  PHASE_W  ROM port B data, valid ROM_LAT cycles after the address

Behaviour:
- Reset (async assert, sync release) sets:
  - rr_ptr = 0, all pipeline valid bits = 0, all pipeline ids = 0
  - rsp_valid = 0, rsp_dphi = 0
  - during reset gnt = 0 and rom_addr_a = rom_addr_b = 0
- Selection, every cycle, combinational:
  - Scan requesters rr_ptr, rr_ptr+1, ... mod N_REQ.
  - The first requester with req high is winner A; the next distinct one is winner B.
  - gnt bits are set for the winners only; at most 2 bits high; one requester never gets both ports in the same cycle.
  - rom_addr_a = req_idx of winner A, else 0; rom_addr_b = req_idx of winner B, else 0.
- Pointer update on a clock edge with at least one grant: rr_ptr <= (last granted id + 1) mod N_REQ. Last granted id is B if B is granted, else A. With no grant the pointer holds.
- Tracking: two shift pipelines (one per port), each ROM_LAT deep. Each stage holds {valid, id}; stage 0 loads {grant_x, winner_x id}.
- Response register: when the last stage of port x is valid with id k:
  - rsp_dphi[k] <= rom_dout_x
  - rsp_valid[k] <= 1 for one cycle
  - Both ports complete to different ids in the same cycle, so there is no collision.
- Latency: a grant at edge-cycle t produces rsp_valid at cycle t+ROM_LAT+1 (= t+2 at default). Throughput is 2 lookups/cycle.
- Back-to-back: req still high in the cycle after its gnt counts as a new lookup. Responses for a single requester return in issue order, because latency is fixed.
- Same index on both ports is legal; both requesters get identical data.
- There is no backpressure on rsp; requesters must accept every rsp_valid pulse.
- Reset mid-operation: in-flight lookups are discarded and never produce rsp_valid. After release, arbitration restarts at requester 0.
- req_idx of a non-requesting channel is don't-care and must not affect the outputs.

Test Plan:
Bench ROM model: sync, ROM_LAT=1, dout = 3*addr (32-bit), for both ports.
1. After reset, only req[2]=1 with idx 5 at cycle 10 -> gnt=0100 at cycle 10, rom_addr_a=5, rom_addr_b=0; rsp_valid=0100 at cycle 12, rsp_dphi[2]=15; rr_ptr becomes 3.
2. All four req held high from reset release, idx_i = 10+i -> grants {0A,1B}, {2A,3B}, {0A,1B}, ... each cycle; every requester gets rsp_valid every 2nd cycle with 30/33/36/39.
3. rr_ptr=2 (preset by a prior grant to requester 1), req=1010 -> requester 3 on port A, requester 1 on port B; rr_ptr becomes 2.
4. req0 idx 7 and req1 idx 7 in the same cycle -> both granted; both rsp_valid pulse together 2 cycles later with dphi 21.
5. req[0] held 3 cycles with idx 1, 2, 4 -> 3 consecutive gnt pulses; rsp_dphi[0] = 3, 6, 12 on consecutive cycles; port B address stays 0.
6. Grant to requester 1 at cycle t, rst pulsed at t+1 -> no rsp_valid at t+2; rsp_dphi=0; after release with req[1] high, requester 1 gets port A and rr_ptr restarts from 0.
